// File: rtl/cond_negate_serial_if.sv
// Valid/ready bus for the bit-serial conditional negator.
//   in_data/in_negate/in_valid/in_ready : operand side (source -> block)
//   out_data/out_ovf/out_zero/out_valid/out_ready : result side (block -> sink)
// Modports: slave = the negator, master = whatever drives and consumes it.
interface cond_negate_serial_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_negate;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             out_zero;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_negate, in_valid, out_ready,
    output in_ready, out_data, out_ovf, out_zero, out_valid
  );

  modport master (
    output in_data, in_negate, in_valid, out_ready,
    input  in_ready, out_data, out_ovf, out_zero, out_valid
  );
endinterface

// File: rtl/cond_negate_serial.sv
// Bit-serial conditional two's-complement negator.
// Returns the operand unchanged (negate=0) or ~operand+1 (negate=1), one bit
// per clock, LSB first, through a 1-bit adder with a carry flop.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : cond_negate_serial_if.slave (operand in, result out, valid/ready)
// Timing: handshake in cycle T, out_valid rises at T+WIDTH+1, held until
// out_ready; next operand accepted the cycle after the result leaves.
module cond_negate_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cond_negate_serial_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;          // operand, shifted right each bit
  logic [WIDTH-1:0] res_q, res_d;        // result, filled from the MSB end
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_zero_q, acc_zero_d; // all result bits so far are 0

  logic [WIDTH-1:0] out_data_d;
  logic             out_ovf_d;
  logic             out_zero_d;
  logic             out_valid_d;
  logic             in_ready_d;

  // Serial adder slice: conditional invert, then add the running carry
  logic b_bit;
  logic r_bit;
  logic cnt_last;

  assign b_bit    = sr_q[0] ^ neg_q;
  assign r_bit    = b_bit ^ carry_q;
  assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      res_q         <= '0;
      neg_q         <= 1'b0;
      carry_q       <= 1'b0;
      cnt_q         <= '0;
      acc_zero_q    <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ovf   <= 1'b0;
      bus.out_zero  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.in_ready  <= 1'b1;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      res_q         <= res_d;
      neg_q         <= neg_d;
      carry_q       <= carry_d;
      cnt_q         <= cnt_d;
      acc_zero_q    <= acc_zero_d;
      bus.out_data  <= out_data_d;
      bus.out_ovf   <= out_ovf_d;
      bus.out_zero  <= out_zero_d;
      bus.out_valid <= out_valid_d;
      bus.in_ready  <= in_ready_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    res_d      = res_q;
    neg_d      = neg_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    acc_zero_d = acc_zero_q;
    out_data_d = bus.out_data;
    out_ovf_d  = bus.out_ovf;
    out_zero_d = bus.out_zero;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d       = bus.in_data;
          neg_d      = bus.in_negate;
          carry_d    = bus.in_negate;   // the "+1" of ~x+1 enters as carry-in
          cnt_d      = '0;
          acc_zero_d = 1'b1;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        sr_d       = sr_q >> 1;
        res_d      = {r_bit, res_q[WIDTH-1:1]};
        carry_d    = b_bit & carry_q;
        acc_zero_d = acc_zero_q & ~r_bit;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_last) begin
          state_d    = DONE;
          out_data_d = {r_bit, res_q[WIDTH-1:1]};
          out_zero_d = acc_zero_q & ~r_bit;
          // Negation is a bijection, so a negated result of 100..0 can only
          // come from the operand 100..0: checking the result is enough.
          out_ovf_d  = neg_q & acc_zero_q & r_bit;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the upcoming state
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

endmodule
